// File: rtl/banco_registros_pkg.sv
// banco_registros_pkg: shared widths and the hardwired-zero register address.
package banco_registros_pkg;
  localparam int W_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF = $clog2(NREG_DEF);
  localparam int REG0 = 0;
endpackage

// File: rtl/marcador_ocupado.sv
// marcador_ocupado: busy vector for in-flight loads; a set beats a same-cycle clear.
module marcador_ocupado
  import banco_registros_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set1,
  input  logic            set2,
  input  logic [AW-1:0]   set_addr1,
  input  logic [AW-1:0]   set_addr2,
  input  logic            clear1,
  input  logic            clear2,
  input  logic [AW-1:0]   clear_addr1,
  input  logic [AW-1:0]   clear_addr2,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clear1) busy_d[clear_addr1] = 1'b0;
    if (clear2) busy_d[clear_addr2] = 1'b0;
    if (set1) busy_d[set_addr1] = 1'b1;
    if (set2) busy_d[set_addr2] = 1'b1;
    busy_d[REG0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign busy = busy_q;
endmodule

// File: rtl/banco_registros.sv
// banco_registros: dual-issue register file with write bypass and load scoreboard.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE1,
  input  logic          WE2,
  input  logic [AW-1:0] WA1,
  input  logic [AW-1:0] WA2,
  input  logic [W-1:0]  WD1,
  input  logic [W-1:0]  WD2,
  input  logic [AW-1:0] RA1A,
  input  logic [AW-1:0] RA1B,
  input  logic [AW-1:0] RA2A,
  input  logic [AW-1:0] RA2B,
  output logic [W-1:0]  RD1A,
  output logic [W-1:0]  RD1B,
  output logic [W-1:0]  RD2A,
  output logic [W-1:0]  RD2B,
  input  logic          SB_SET1,
  input  logic          SB_SET2,
  input  logic [AW-1:0] SB_ADDR1,
  input  logic [AW-1:0] SB_ADDR2,
  output logic          HAZ1,
  output logic          HAZ2
);
  logic [W-1:0] rf_q [NREG];
  logic [NREG-1:0] busy;
  logic we1_nz, we2_nz;
  assign we1_nz = WE1 && WA1 != AW'(REG0);
  assign we2_nz = WE2 && WA2 != AW'(REG0);
  // lane 2 is the younger instruction, so its write lands last
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (we1_nz) rf_q[WA1] <= WD1;
      if (we2_nz) rf_q[WA2] <= WD2;
    end
  end
  marcador_ocupado #(.NREG(NREG)) u_sb (
    .clk(clk),
    .reset(reset),
    .set1(SB_SET1),
    .set2(SB_SET2),
    .set_addr1(SB_ADDR1),
    .set_addr2(SB_ADDR2),
    .clear1(WE1),
    .clear2(WE2),
    .clear_addr1(WA1),
    .clear_addr2(WA2),
    .busy(busy)
  );
  function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
    return (a == AW'(REG0)) ? '0 :
           (we2_nz && WA2 == a) ? WD2 :
           (we1_nz && WA1 == a) ? WD1 : rf_q[a];
  endfunction
  function automatic logic haz(input logic [AW-1:0] a);
    return a != AW'(REG0) && busy[a] && !(WE1 && WA1 == a) && !(WE2 && WA2 == a);
  endfunction
  always_comb begin
    RD1A = rd(RA1A);
    RD1B = rd(RA1B);
    RD2A = rd(RA2A);
    RD2B = rd(RA2B);
    HAZ1 = haz(RA1A) || haz(RA1B);
    HAZ2 = haz(RA2A) || haz(RA2B);
  end
endmodule
